uart_tx_scheduler: RTL and testbench
====================================

// Module: uart_tx_scheduler
// PURPOSE
//   Shares one UART transmit engine among NUM_REQ byte-stream requesters in the
//   interdevice controller. Round-robin arbitration; a grant is held for one
//   burst (until req_last or MAX_BURST bytes). Sequences the engine with a
//   start/done handshake and enforces an idle gap, in baud ticks, between bursts.
// PARAMETERS
//   NUM_REQ      4   number of requesters (>=2)
//   DATA_WIDTH   8   byte width presented to the TX engine
//   MAX_BURST    4   max bytes per grant before forced re-arbitration (>=1)
//   GAP_TICKS    2   baud_tick pulses of line idle between bursts (0 = none)
//   STALL_LIMIT  16  cycles of req_valid low in SEND before grant is revoked
// PORTS
//   clk          in   1                   system clock
//   rst          in   1                   synchronous reset, active-high
//   req_valid    in   NUM_REQ             per-requester byte valid
//   req_data     in   NUM_REQ*DATA_WIDTH  packed bytes, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_last     in   NUM_REQ             byte is last of requester's burst
//   req_ready    out  NUM_REQ             one-hot accept, combinational from state/tx_busy
//   baud_tick    in   1                   1-cycle pulse per bit period from the uart clock divider
//   tx_busy      in   1                   TX engine serialising a frame
//   tx_done      in   1                   1-cycle pulse at end of stop bit
//   tx_start     out  1                   1-cycle registered start pulse to TX engine
//   tx_data      out  DATA_WIDTH          byte for TX engine, valid with tx_start, held after
//   grant_valid  out  1                   a requester currently owns the engine
//   grant_id     out  $clog2(NUM_REQ)     owning requester index
// BEHAVIOUR
//   Reset: state IDLE; tx_start=0, tx_data=0, grant_valid=0, grant_id=0, req_ready=0,
//     burst_cnt=0, gap_cnt=0, stall_cnt=0, last_grant=NUM_REQ-1 (requester 0 wins first).
//     Reset mid-burst aborts immediately; no further tx_start; the TX engine is not flushed.
//   FSM states IDLE, SEND, WAIT, GAP.
//   IDLE: if |req_valid, grant_id <= first i with req_valid[i], searching
//     last_grant+1, +2, ... mod NUM_REQ; grant_valid<=1; burst_cnt<=0; -> SEND.
//     Arbitration is registered: grant appears 1 cycle after req_valid.
//   SEND: req_ready[grant_id] = !tx_busy; all other req_ready bits 0.
//     Handshake (req_valid & req_ready on grant_id): next cycle tx_start=1,
//     tx_data=byte, last_flag<=req_last, burst_cnt+1, stall_cnt<=0; -> WAIT.
//     req_valid[grant_id] low: stall_cnt+1; at STALL_LIMIT -> GAP (grant revoked).
//     Valids from non-granted requesters are ignored (no preemption).
//   WAIT: req_ready all 0. On tx_done: if last_flag or burst_cnt==MAX_BURST -> GAP,
//     else -> SEND. tx_done in any other state is ignored.
//   GAP: grant_valid<=0; last_grant<=grant_id; gap_cnt counts baud_tick pulses;
//     -> IDLE when gap_cnt reaches GAP_TICKS (GAP_TICKS=0: GAP lasts exactly 1 cycle).
//   Simultaneous events: baud_tick and entry to GAP in same cycle not counted.
//   Widths: burst_cnt $clog2(MAX_BURST+1), gap_cnt $clog2(GAP_TICKS+1), stall_cnt
//     $clog2(STALL_LIMIT+1); none wrap, each saturates at its limit.
//   Throughput: one byte per TX frame; tx_start never asserted while tx_busy=1.
// TESTING
//   T1 single: req0 sends 0xA5 with last -> grant_id=0 next cycle, tx_start 1 cycle,
//      tx_data=0xA5; after tx_done + 2 baud_ticks grant_valid=0, state IDLE.
//   T2 round-robin: req0..3 all valid, 1-byte bursts with last -> grant order 0,1,2,3,0.
//   T3 burst cap: req1 streams 6 bytes 0x10..0x15, no last; req2 valid ->
//      0x10..0x13 from req1, then req2 granted, then req1 resumes with 0x14.
//   T4 stall: grantee drops req_valid for 16 cycles -> grant revoked, next requester
//      granted after gap; no tx_start during stall.
//   T5 busy gating: hold tx_busy=1 in SEND -> req_ready stays 0, no tx_start.
//   T6 reset mid-WAIT: assert rst 1 cycle -> all outputs 0, next grant goes to req0.

Source files
------------

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART TX engine among NUM_REQ byte-stream
// requesters, with burst capping, stall revocation and an inter-burst idle gap.
module uart_tx_scheduler #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned MAX_BURST   = 4,
  parameter int unsigned GAP_TICKS   = 2,
  parameter int unsigned STALL_LIMIT = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  input  logic [NUM_REQ-1:0]              req_last,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic                            baud_tick,
  input  logic                            tx_busy,
  input  logic                            tx_done,
  output logic                            tx_start,
  output logic [DATA_WIDTH-1:0]           tx_data,
  output logic                            grant_valid,
  output logic [$clog2(NUM_REQ)-1:0]      grant_id
);

  localparam int unsigned IW = $clog2(NUM_REQ);
  localparam int unsigned BW = $clog2(MAX_BURST + 1);
  localparam int unsigned GW = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;
  localparam int unsigned SW = $clog2(STALL_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT, GAP} state_t;

  state_t          state;
  logic [IW-1:0]   last_grant;
  logic [BW-1:0]   burst_cnt;
  logic [GW-1:0]   gap_cnt;
  logic [SW-1:0]   stall_cnt;
  logic            last_flag;

  logic [IW-1:0]          arb_id;
  logic                   sel_valid;
  logic                   sel_last;
  logic [DATA_WIDTH-1:0]  sel_data;
  logic                   handshake;
  logic [GW:0]            gap_inc;
  logic                   gap_done;

  // Round-robin search starting just after the previous owner; lowest offset wins.
  always_comb begin
    int unsigned idx;
    idx    = 0;
    arb_id = '0;
    for (int j = NUM_REQ; j >= 1; j--) begin
      idx = (int'(last_grant) + j) % NUM_REQ;
      if (req_valid[IW'(idx)]) arb_id = IW'(idx);
    end
  end

  // Owner's request lines and accept generation.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == IW'(i)) begin
        sel_valid = req_valid[i];
        sel_last  = req_last[i];
        sel_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    req_ready = '0;
    if (state == SEND) req_ready[grant_id] = !tx_busy;
    handshake = (state == SEND) && sel_valid && !tx_busy;
    gap_inc   = {1'b0, gap_cnt} + (GW+1)'(baud_tick);
    gap_done  = gap_inc >= (GW+1)'(GAP_TICKS);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      tx_start    <= 1'b0;
      tx_data     <= '0;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      last_grant  <= IW'(NUM_REQ - 1);
      burst_cnt   <= '0;
      gap_cnt     <= '0;
      stall_cnt   <= '0;
      last_flag   <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      case (state)
        IDLE: begin
          if (|req_valid) begin
            grant_id    <= arb_id;
            grant_valid <= 1'b1;
            burst_cnt   <= '0;
            stall_cnt   <= '0;
            state       <= SEND;
          end
        end
        SEND: begin
          if (handshake) begin
            tx_start  <= 1'b1;
            tx_data   <= sel_data;
            last_flag <= sel_last;
            if (burst_cnt != BW'(MAX_BURST)) burst_cnt <= burst_cnt + BW'(1);
            stall_cnt <= '0;
            state     <= WAIT;
          end else if (!sel_valid) begin
            if (stall_cnt != SW'(STALL_LIMIT)) stall_cnt <= stall_cnt + SW'(1);
            // Owner went quiet too long: revoke the grant.
            if (stall_cnt >= SW'(STALL_LIMIT - 1)) begin
              gap_cnt <= '0;
              state   <= GAP;
            end
          end
        end
        WAIT: begin
          if (tx_done) begin
            if (last_flag || burst_cnt == BW'(MAX_BURST)) begin
              gap_cnt <= '0;
              state   <= GAP;
            end else begin
              state <= SEND;
            end
          end
        end
        GAP: begin
          grant_valid <= 1'b0;
          last_grant  <= grant_id;
          gap_cnt     <= gap_done ? GW'(GAP_TICKS) : gap_inc[GW-1:0];
          if (gap_done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench for uart_tx_scheduler: behavioural requesters and TX engine,
// expected grants and bytes queued at stimulus time and compared on DUT output.
module tb_uart_tx_scheduler;

  localparam int NR    = 4;
  localparam int DW    = 8;
  localparam int FRAME = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_valid;
  logic [NR*DW-1:0]  req_data;
  logic [NR-1:0]     req_last;
  logic [NR-1:0]     req_ready;
  logic              baud_tick;
  logic              tx_busy;
  logic              tx_done;
  logic              tx_start;
  logic [DW-1:0]     tx_data;
  logic              grant_valid;
  logic [1:0]        grant_id;

  always #5 clk = ~clk;

  uart_tx_scheduler #(
    .NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(4), .GAP_TICKS(2), .STALL_LIMIT(16)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .baud_tick(baud_tick), .tx_busy(tx_busy), .tx_done(tx_done),
    .tx_start(tx_start), .tx_data(tx_data),
    .grant_valid(grant_valid), .grant_id(grant_id)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [8:0]  rq [NR][$];
  logic [15:0] exp_tx [$];
  int          exp_gnt [$];
  logic [NR-1:0] en = '0;
  logic [NR-1:0] hs_prev = '0;
  int  eng_cnt = 0;
  int  tick_div = 0;
  int  ticks_seen = 0;
  bit  after_done = 0;
  bit  force_busy = 0;
  bit  busy_prev = 0;
  bit  prev_gv = 0;
  bit  seen_start = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=0x%0h want=0x%0h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic add_byte(input int id, input logic [7:0] d, input bit last);
    rq[id].push_back({last, d});
  endtask

  task automatic expect_tx(input int id, input logic [7:0] d);
    exp_tx.push_back({8'(id), d});
  endtask

  // One clock: observe DUT outputs, then step engine/baud/requester models.
  task automatic cycle();
    logic [15:0] e;
    int g;
    @(negedge clk);
    for (int i = 0; i < NR; i++)
      if (hs_prev[i] && rq[i].size() > 0) void'(rq[i].pop_front());
    seen_start = 0;
    if (tx_start) begin
      seen_start = 1;
      check("start_while_busy", 32'(busy_prev), 32'd0);
      check("tx_sb_nonempty", 32'(exp_tx.size() != 0), 32'd1);
      if (exp_tx.size() != 0) begin
        e = exp_tx.pop_front();
        check("tx_id", 32'(grant_id), 32'(e[15:8]));
        check("tx_data", 32'(tx_data), 32'(e[7:0]));
      end
      eng_cnt = FRAME;
    end
    if (grant_valid && !prev_gv) begin
      check("gnt_sb_nonempty", 32'(exp_gnt.size() != 0), 32'd1);
      if (exp_gnt.size() != 0) begin
        g = exp_gnt.pop_front();
        check("grant_id", 32'(grant_id), 32'(g));
      end
      if (after_done) check("gap_ticks", 32'(ticks_seen >= 2), 32'd1);
      after_done = 0;
    end
    prev_gv = grant_valid;
    check("ready_owner",
          32'(req_ready == '0 || (grant_valid && req_ready == (NR'(1) << grant_id))), 32'd1);

    tx_done = 1'b0;
    if (eng_cnt > 0) begin
      eng_cnt--;
      if (eng_cnt == 0) tx_done = 1'b1;
    end
    tx_busy   = force_busy || (eng_cnt > 0);
    baud_tick = (tick_div == 2);
    tick_div  = (tick_div + 1) % 3;
    if (tx_done && grant_valid) begin
      after_done = 1;
      ticks_seen = 0;
    end else if (baud_tick) begin
      ticks_seen++;
    end
    for (int i = 0; i < NR; i++) begin
      req_valid[i] = en[i] && (rq[i].size() > 0);
      if (rq[i].size() > 0) {req_last[i], req_data[i*DW +: DW]} = rq[i][0];
    end
    #1;
    hs_prev   = req_valid & req_ready;
    busy_prev = tx_busy;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    after_done = 0;
  endtask

  task automatic wait_idle(input string tag);
    int  n;
    bit  ok;
    bit  empty;
    n  = 0;
    ok = 0;
    while (n < 400 && !ok) begin
      cycle();
      n++;
      empty = (exp_tx.size() == 0) && (exp_gnt.size() == 0);
      for (int i = 0; i < NR; i++) if (rq[i].size() != 0) empty = 0;
      ok = empty && !grant_valid && !tx_busy;
    end
    check(tag, 32'(ok), 32'd1);
    repeat (10) cycle();
    en = '0;
  endtask

  task automatic wait_start(input string tag);
    int n;
    n = 0;
    seen_start = 0;
    while (n < 100 && !seen_start) begin
      cycle();
      n++;
    end
    check(tag, 32'(seen_start), 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0; req_data = '0; req_last = '0;
    baud_tick = 1'b0; tx_busy = 1'b0; tx_done = 1'b0;
    repeat (3) cycle();
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_grant_valid", 32'(grant_valid), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    rst = 1'b0;

    // T1 single byte, registered arbitration
    add_byte(0, 8'hA5, 1); expect_tx(0, 8'hA5); exp_gnt.push_back(0);
    en = 4'b0001;
    cycle();
    cycle();
    check("t1_grant_valid", 32'(grant_valid), 32'd1);
    check("t1_grant_id", 32'(grant_id), 32'd0);
    wait_idle("t1_idle");
    check("t1_released", 32'(grant_valid), 32'd0);

    // T2 round robin from reset: 0,1,2,3,0
    do_reset();
    add_byte(0, 8'h01, 1); add_byte(0, 8'h02, 1);
    add_byte(1, 8'h11, 1); add_byte(2, 8'h21, 1); add_byte(3, 8'h31, 1);
    foreach (exp_gnt[k]) exp_gnt[k] = exp_gnt[k];
    exp_gnt.push_back(0); exp_gnt.push_back(1); exp_gnt.push_back(2);
    exp_gnt.push_back(3); exp_gnt.push_back(0);
    expect_tx(0, 8'h01); expect_tx(1, 8'h11); expect_tx(2, 8'h21);
    expect_tx(3, 8'h31); expect_tx(0, 8'h02);
    en = 4'b1111;
    wait_idle("t2_idle");

    // T3 burst cap forces re-arbitration after 4 bytes
    for (int b = 0; b < 6; b++) add_byte(1, 8'(8'h10 + b), b == 5);
    add_byte(2, 8'h20, 1);
    exp_gnt.push_back(1); exp_gnt.push_back(2); exp_gnt.push_back(1);
    for (int b = 0; b < 4; b++) expect_tx(1, 8'(8'h10 + b));
    expect_tx(2, 8'h20); expect_tx(1, 8'h14); expect_tx(1, 8'h15);
    en = 4'b0110;
    wait_idle("t3_idle");

    // T4 stall revocation, no preemption by requester 3
    add_byte(2, 8'h30, 0); add_byte(3, 8'h40, 1);
    exp_gnt.push_back(2); exp_gnt.push_back(3);
    expect_tx(2, 8'h30); expect_tx(3, 8'h40);
    en = 4'b1100;
    wait_start("t4_start");
    repeat (14) cycle();
    check("t4_hold_valid", 32'(grant_valid), 32'd1);
    check("t4_hold_id", 32'(grant_id), 32'd2);
    wait_idle("t4_idle");

    // T5 busy gating holds off the handshake
    force_busy = 1;
    add_byte(0, 8'h50, 1); exp_gnt.push_back(0);
    en = 4'b0001;
    for (int c = 0; c < 12; c++) begin
      cycle();
      check("t5_ready", 32'(req_ready), 32'd0);
    end
    check("t5_grant_valid", 32'(grant_valid), 32'd1);
    check("t5_grant_id", 32'(grant_id), 32'd0);
    expect_tx(0, 8'h50);
    force_busy = 0;
    wait_idle("t5_idle");

    // T6 reset during WAIT, next grant restarts at requester 0
    add_byte(1, 8'h60, 0); add_byte(1, 8'h61, 1);
    exp_gnt.push_back(1); exp_gnt.push_back(0); exp_gnt.push_back(1);
    expect_tx(1, 8'h60); expect_tx(0, 8'h70); expect_tx(1, 8'h61);
    en = 4'b0010;
    wait_start("t6_start");
    add_byte(0, 8'h70, 1);
    en = 4'b0011;
    do_reset();
    check("t6_tx_start", 32'(tx_start), 32'd0);
    check("t6_tx_data", 32'(tx_data), 32'd0);
    check("t6_grant_valid", 32'(grant_valid), 32'd0);
    check("t6_grant_id", 32'(grant_id), 32'd0);
    check("t6_req_ready", 32'(req_ready), 32'd0);
    wait_idle("t6_idle");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
